// File: rtl/acc_sequencer.sv
// acc_sequencer: walks every output pixel after the kij passes have filled
// pmem. Per pixel it clears the SFP, issues the 9 pmem reads with matching
// acc strobes, captures sfp_out and hands the vector downstream on a
// valid/ready handshake. Outputs are produced in raster order.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-low reset
//   start      1-cycle pulse, begins a run (honoured only in IDLE)
//   CEN_pmem   pmem chip enable, active-low (low only while reading)
//   WEN_pmem   pmem write enable, active-low, tied high (read only)
//   A_pmem     pmem read address
//   acc        SFP accumulate strobe (read strobe delayed one cycle)
//   sfp_clr    SFP accumulator clear pulse
//   sfp_out    SFP accumulated result
//   out_data   captured output vector
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   out_idx    index of the output currently presented
//   busy       run in progress
//   done       1-cycle pulse after the last output is accepted
module acc_sequencer #(
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int addr_bw = 11,
   parameter int ksize   = 3,
   parameter int in_w    = 6,
   parameter int o_w     = 4,
   parameter int kstride = 36
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     CEN_pmem,
   output logic                     WEN_pmem,
   output logic [addr_bw-1:0]       A_pmem,
   output logic                     acc,
   output logic                     sfp_clr,
   input  logic [col*psum_bw-1:0]   sfp_out,
   output logic [col*psum_bw-1:0]   out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               out_idx,
   output logic                     busy,
   output logic                     done
);

   localparam int NPASS = ksize * ksize;
   localparam int NOUT  = o_w * o_w;
   localparam int KW    = $clog2(NPASS + 1);
   localparam int KJW   = (ksize > 1) ? $clog2(ksize) : 1;
   localparam int OCW   = (o_w > 1) ? $clog2(o_w) : 1;

   // Address increments: stepping kj moves one word right in the next kij
   // block; wrapping kj back to 0 also drops one input row.
   localparam logic [addr_bw-1:0] STEP_COL = addr_bw'(kstride + 1);
   localparam logic [addr_bw-1:0] STEP_ROW = addr_bw'(kstride + in_w - ksize + 1);
   localparam logic [addr_bw-1:0] PIX_COL  = addr_bw'(1);
   localparam logic [addr_bw-1:0] PIX_ROW  = addr_bw'(in_w - o_w + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_RD, S_DRAIN, S_SETTLE, S_OUT, S_FIN
   } state_t;

   state_t                   r_state, w_next;
   logic [KW-1:0]            r_kij;
   logic [KJW-1:0]           r_kj;
   logic [OCW-1:0]           r_oc;
   logic [3:0]               r_idx;
   logic [addr_bw-1:0]       r_pix_base;
   logic [addr_bw-1:0]       r_addr;
   logic                     r_acc;
   logic [col*psum_bw-1:0]   r_out_data;
   logic                     w_last_kij;
   logic                     w_last_out;

   assign w_last_kij = (r_kij == KW'(NPASS - 1));
   assign w_last_out = (r_idx == 4'(NOUT - 1));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_CLR;
         S_CLR:    w_next = S_RD;
         S_RD:     if (w_last_kij) w_next = S_DRAIN;
         S_DRAIN:  w_next = S_SETTLE;
         S_SETTLE: w_next = S_OUT;
         S_OUT:    if (out_ready) w_next = w_last_out ? S_FIN : S_CLR;
         S_FIN:    w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      CEN_pmem  = (r_state != S_RD);
      WEN_pmem  = 1'b1;
      A_pmem    = (r_state == S_RD) ? r_addr : '0;
      sfp_clr   = (r_state == S_CLR);
      out_valid = (r_state == S_OUT);
      busy      = (r_state != S_IDLE);
      done      = (r_state == S_FIN);
      acc       = r_acc;
      out_data  = r_out_data;
      out_idx   = r_idx;
   end

   // Counters and capture. The address is built incrementally: r_pix_base
   // tracks o_r*in_w + o_c, r_addr walks the 9 kernel taps from it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_kij      <= '0;
         r_kj       <= '0;
         r_oc       <= '0;
         r_idx      <= '0;
         r_pix_base <= '0;
         r_addr     <= '0;
         r_acc      <= 1'b0;
         r_out_data <= '0;
      end else begin
         r_acc <= (r_state == S_RD);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_idx      <= '0;
                  r_oc       <= '0;
                  r_pix_base <= '0;
               end
            end
            S_CLR: begin
               r_kij  <= '0;
               r_kj   <= '0;
               r_addr <= r_pix_base;
            end
            S_RD: begin
               r_kij <= r_kij + KW'(1);
               if (r_kj == KJW'(ksize - 1)) begin
                  r_kj   <= '0;
                  r_addr <= r_addr + STEP_ROW;
               end else begin
                  r_kj   <= r_kj + KJW'(1);
                  r_addr <= r_addr + STEP_COL;
               end
            end
            S_SETTLE: r_out_data <= sfp_out;
            S_OUT: begin
               if (out_ready && !w_last_out) begin
                  r_idx <= r_idx + 4'd1;
                  if (r_oc == OCW'(o_w - 1)) begin
                     r_oc       <= '0;
                     r_pix_base <= r_pix_base + PIX_ROW;
                  end else begin
                     r_oc       <= r_oc + OCW'(1);
                     r_pix_base <= r_pix_base + PIX_COL;
                  end
               end
            end
            S_FIN: begin
               r_idx      <= '0;
               r_oc       <= '0;
               r_pix_base <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_sequencer.sv
module tb_acc_sequencer;
   localparam int PBW = 16;
   localparam int COL = 8;
   localparam int ABW = 11;
   localparam int DW  = PBW * COL;

   logic            clk = 1'b0;
   logic            reset, start, out_ready;
   logic            CEN_pmem, WEN_pmem, acc, sfp_clr, out_valid, busy, done;
   logic [ABW-1:0]  A_pmem;
   logic [DW-1:0]   sfp_out, out_data;
   logic [3:0]      out_idx;

   always #5 clk = ~clk;

   acc_sequencer #(
      .psum_bw(16), .col(8), .addr_bw(11), .ksize(3),
      .in_w(6), .o_w(4), .kstride(36)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .CEN_pmem(CEN_pmem), .WEN_pmem(WEN_pmem), .A_pmem(A_pmem),
      .acc(acc), .sfp_clr(sfp_clr), .sfp_out(sfp_out),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .busy(busy), .done(done)
   );

   // Known pmem contents: column c of word a holds a*3 + c*100 + 1.
   function automatic logic [DW-1:0] pmem_word(input int unsigned a);
      logic [DW-1:0] w;
      w = '0;
      for (int c = 0; c < COL; c++) w[c*PBW +: PBW] = 16'(a * 3 + c * 100 + 1);
      return w;
   endfunction

   // Behavioural pmem (1-cycle read latency) and SFP accumulator.
   logic [DW-1:0] pm_q   = '0;
   logic [DW-1:0] sfp_acc = '0;
   always @(posedge clk) if (!CEN_pmem) pm_q <= pmem_word(int'(A_pmem));
   always @(posedge clk) begin
      if (sfp_clr) sfp_acc <= '0;
      else if (acc)
         for (int c = 0; c < COL; c++)
            sfp_acc[c*PBW +: PBW] <= sfp_acc[c*PBW +: PBW] + pm_q[c*PBW +: PBW];
   end
   assign sfp_out = sfp_acc;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]    idx;
      logic [DW-1:0] data;
   } out_t;

   out_t            exp_out[$];
   logic [ABW-1:0]  exp_addr[$];
   int unsigned     A0[9] = '{0, 37, 74, 114, 151, 188, 228, 265, 302};
   logic [ABW-1:0]  last_addr = '0;
   int              done_cnt = 0;

   // Expected address trace and output vectors for one full run.
   task automatic push_run();
      for (int o = 0; o < 16; o++) begin
         out_t        e;
         int unsigned a, orow, ocol;
         orow   = o / 4;
         ocol   = o % 4;
         e.idx  = 4'(o);
         e.data = '0;
         for (int k = 0; k < 9; k++) begin
            logic [DW-1:0] w;
            a = (o == 0) ? A0[k] : k * 36 + (orow + k / 3) * 6 + ocol + k % 3;
            exp_addr.push_back(ABW'(a));
            w = pmem_word(a);
            for (int c = 0; c < COL; c++)
               e.data[c*PBW +: PBW] = e.data[c*PBW +: PBW] + w[c*PBW +: PBW];
         end
         exp_out.push_back(e);
      end
   endtask

   // Monitor: address trace, acc timing, and output scoreboard.
   bit prev_valid = 0;
   bit prev_rd    = 0;
   int acc_cnt    = 0;
   always @(negedge clk) begin
      if (reset) begin
         if (!CEN_pmem) begin
            check("WEN_pmem", DW'(WEN_pmem), DW'(1));
            if (exp_addr.size() == 0) begin
               total++; bad++;
               $display("FAIL A_pmem_unexpected: got %0d expected no read", A_pmem);
            end else begin
               check("A_pmem", DW'(A_pmem), DW'(exp_addr.pop_front()));
            end
            last_addr = A_pmem;
         end
         if (prev_valid) check("acc_lag", DW'(acc), DW'(prev_rd));
         prev_rd    = !CEN_pmem;
         prev_valid = 1;
         if (acc) acc_cnt++;
         if (out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
               total++; bad++;
               $display("FAIL out_unexpected: got idx %0d expected no output", out_idx);
            end else begin
               out_t e;
               e = exp_out.pop_front();
               check("out_idx", DW'(out_idx), DW'(e.idx));
               check("out_data", out_data, e.data);
            end
            check("acc_count", DW'(acc_cnt), DW'(9));
            acc_cnt = 0;
         end
         if (done) done_cnt++;
      end else begin
         prev_valid = 0;
         acc_cnt    = 0;
      end
   end

   task automatic check_reset_vals();
      check("rst_CEN", DW'(CEN_pmem), DW'(1));
      check("rst_WEN", DW'(WEN_pmem), DW'(1));
      check("rst_A", DW'(A_pmem), DW'(0));
      check("rst_acc", DW'(acc), DW'(0));
      check("rst_sfp_clr", DW'(sfp_clr), DW'(0));
      check("rst_out_data", out_data, DW'(0));
      check("rst_out_valid", DW'(out_valid), DW'(0));
      check("rst_out_idx", DW'(out_idx), DW'(0));
      check("rst_busy", DW'(busy), DW'(0));
      check("rst_done", DW'(done), DW'(0));
   endtask

   // Counts cycles from the cycle after start is sampled until done.
   task automatic wait_done(input string name, input bit check_cycle);
      int n;
      bit seen;
      n = 0;
      seen = 0;
      while (!seen && n < 400) begin
         @(negedge clk);
         n++;
         if (done) seen = 1;
      end
      if (check_cycle || !seen) check(name, DW'(n), DW'(209));
   endtask

   task automatic wait_idx(input int idx, input bit need_rd);
      int n;
      bit ok;
      n = 0;
      ok = 0;
      while (!ok && n < 400) begin
         @(negedge clk);
         n++;
         if (out_idx == 4'(idx) && (!need_rd || !CEN_pmem)) ok = 1;
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL wait_idx: got timeout expected out_idx %0d", idx);
      end
   endtask

   task automatic run_end_checks(input int d0);
      @(negedge clk);
      check("done_once", DW'(done_cnt - d0), DW'(1));
      check("done_low_after", DW'(done), DW'(0));
      check("busy_idle", DW'(busy), DW'(0));
      check("last_addr", DW'(last_addr), DW'(323));
      check("out_queue_empty", DW'(exp_out.size()), DW'(0));
      check("addr_queue_empty", DW'(exp_addr.size()), DW'(0));
   endtask

   initial begin
      int d0;
      reset     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals();
      @(posedge clk); #1 reset = 1'b1;

      // Run 1: free-running, done timing.
      push_run();
      d0 = done_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("busy_run", DW'(busy), DW'(1));
      wait_done("done_cycle", 1);
      run_end_checks(d0);

      // Run 2: back-to-back start, spurious start in RD of output 3,
      // 20-cycle stall at output 5.
      push_run();
      d0 = done_cnt;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_idx(3, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idx(5, 0);
      out_ready = 1'b0;
      begin
         int n;
         n = 0;
         while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      for (int i = 0; i < 20; i++) begin
         check("stall_valid", DW'(out_valid), DW'(1));
         check("stall_idx", DW'(out_idx), DW'(5));
         if (exp_out.size() > 0) check("stall_data", out_data, exp_out[0].data);
         check("stall_CEN", DW'(CEN_pmem), DW'(1));
         check("stall_acc", DW'(acc), DW'(0));
         @(negedge clk);
      end
      out_ready = 1'b1;
      wait_done("done_run2", 0);
      run_end_checks(d0);

      // Run 3: reset mid-RD of output 7.
      push_run();
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_idx(7, 1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_vals();
      exp_out.delete();
      exp_addr.delete();
      repeat (3) @(negedge clk);
      check_reset_vals();

      // Run 4: start coincident with reset release, restarts from output 0.
      push_run();
      d0 = done_cnt;
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done("done_cycle_after_reset", 1);
      run_end_checks(d0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
